// File: rtl/lsu_ctrl_pkg.sv
// lsu_ctrl_pkg: access-size, error and state encodings plus lane decode helpers
package lsu_ctrl_pkg;
  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic EXT_SIGNED = 1'b1;
  typedef enum logic [1:0] {LSU_IDLE = 2'b00, LSU_MEM = 2'b01, LSU_RESP = 2'b10} lsu_state_e;
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    return size == MEM_BYTE ? 4'b0001 << off : size == MEM_HALF ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return size == MEM_BYTE ? 1'b0 : size == MEM_HALF ? off[0] : off != 2'b00;
  endfunction
endpackage

// File: rtl/load_align.sv
// load_align: selects the addressed byte/half lane of a read word and extends it
module load_align
  import lsu_ctrl_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        ext_i,
  output logic [31:0] data_o
);
  logic [7:0] b;
  logic [15:0] h;
  logic sgn;
  always_comb begin
    b = rdata_i[{off_i, 3'b000} +: 8];
    h = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    sgn = ext_i == EXT_SIGNED;
    data_o = size_i == MEM_BYTE ? {{24{sgn & b[7]}}, b} :
             size_i == MEM_HALF ? {{16{sgn & h[15]}}, h} : rdata_i;
  end
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: issues one aligned memory access per request, waits for ack or timeout,
// and returns extended load data or a store completion as a one-cycle response.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_ext,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err
);
  lsu_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] size_q, size_d, off_q, off_d, rsp_err_q, rsp_err_d;
  logic ext_q, ext_d, mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d, rsp_rdata_q, rsp_rdata_d;
  logic [3:0] mem_be_q, mem_be_d;
  logic [31:0] ld_data;
  logic mis;
  load_align u_align (
    .rdata_i(mem_rdata),
    .off_i  (off_q),
    .size_i (size_q),
    .ext_i  (ext_q),
    .data_o (ld_data)
  );
  assign req_ready = rstn && state_q == LSU_IDLE;
  assign mem_req = state_q == LSU_MEM;
  assign rsp_valid = state_q == LSU_RESP;
  assign mem_we = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_be = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err = rsp_err_q;
  assign mis = misaligned(req_size, req_addr[1:0]);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    size_d = size_q;
    off_d = off_q;
    ext_d = ext_q;
    mem_we_d = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_be_d = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d = rsp_err_q;
    case (state_q)
      LSU_IDLE: if (req_valid) begin
        state_d = mis ? LSU_RESP : LSU_MEM;
        cnt_d = 8'd0;
        size_d = req_size;
        off_d = req_addr[1:0];
        ext_d = req_ext;
        mem_we_d = req_we;
        mem_addr_d = {req_addr[31:2], 2'b00};
        mem_be_d = byte_en(req_size, req_addr[1:0]);
        mem_wdata_d = req_size == MEM_BYTE ? {4{req_wdata[7:0]}} :
                      req_size == MEM_HALF ? {2{req_wdata[15:0]}} : req_wdata;
        rsp_rdata_d = 32'd0;
        rsp_err_d = mis ? ERR_MISALIGN : ERR_NONE;
      end
      LSU_MEM: begin
        // ack takes priority over a timeout landing in the same cycle
        if (mem_ack) begin
          state_d = LSU_RESP;
          rsp_rdata_d = mem_we_q ? 32'd0 : ld_data;
          rsp_err_d = ERR_NONE;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_d = LSU_RESP;
          rsp_rdata_d = 32'd0;
          rsp_err_d = ERR_TIMEOUT;
        end else cnt_d = cnt_q + 8'd1;
      end
      default: state_d = LSU_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= LSU_IDLE;
      cnt_q <= 8'd0;
      size_q <= 2'b00;
      off_q <= 2'b00;
      ext_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_addr_q <= 32'd0;
      mem_be_q <= 4'd0;
      mem_wdata_q <= 32'd0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q <= ERR_NONE;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      size_q <= size_d;
      off_q <= off_d;
      ext_q <= ext_d;
      mem_we_q <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_be_q <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q <= rsp_err_d;
    end
  end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed tests of lsu_ctrl with TIMEOUT=4
module tb_lsu_ctrl;
  logic clk = 1'b0, rstn = 1'b0;
  logic req_valid = 1'b0, req_we = 1'b0, req_ext = 1'b0, mem_ack = 1'b0;
  logic [1:0] req_size = 2'b00;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0, mem_rdata = 32'd0;
  logic req_ready, mem_req, mem_we, rsp_valid;
  logic [31:0] mem_addr, mem_wdata, rsp_rdata;
  logic [3:0] mem_be;
  logic [1:0] rsp_err;
  int checks = 0, failures = 0;
  lsu_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_ext(req_ext), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [1:0] sz, input logic ex, input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1; req_we = we; req_size = sz; req_ext = ex; req_addr = a; req_wdata = wd;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL issue_ready: got %b expected 1", req_ready);
    end
    step;
    req_valid = 1'b0;
  endtask

  task automatic do_access(input string nm, input logic we, input logic [1:0] sz, input logic ex,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                           input logic [31:0] xaddr, input logic [3:0] xbe, input logic [31:0] xwd,
                           input logic [31:0] xrd);
    issue(we, sz, ex, a, wd);
    chk({nm, "_mem_req"}, {31'd0, mem_req}, 32'd1);
    chk({nm, "_mem_we"}, {31'd0, mem_we}, {31'd0, we});
    chk({nm, "_mem_addr"}, mem_addr, xaddr);
    chk({nm, "_mem_be"}, {28'd0, mem_be}, {28'd0, xbe});
    if (we) chk({nm, "_mem_wdata"}, mem_wdata, xwd);
    mem_ack = 1'b1; mem_rdata = rd;
    step;
    mem_ack = 1'b0;
    chk({nm, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({nm, "_rsp_rdata"}, rsp_rdata, xrd);
    chk({nm, "_rsp_err"}, {30'd0, rsp_err}, 32'd0);
    chk({nm, "_mem_req_drop"}, {31'd0, mem_req}, 32'd0);
    step;
    chk({nm, "_rsp_done"}, {31'd0, rsp_valid}, 32'd0);
    chk({nm, "_ready_again"}, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    step; step;
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rsp", {29'd0, rsp_valid, rsp_err}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    rstn = 1'b1;
    #1;
    chk("rst_ready_release", {31'd0, req_ready}, 32'd1);
    step;
  endtask

  task automatic test_loads;
    do_access("lb_signed", 1'b0, 2'b00, 1'b1, 32'h103, 32'd0, 32'h80FF_0000, 32'h100, 4'b1000, 32'd0, 32'hFFFF_FF80);
    do_access("lh_unsigned", 1'b0, 2'b01, 1'b0, 32'h202, 32'd0, 32'h9ABC_1234, 32'h200, 4'b1100, 32'd0, 32'h0000_9ABC);
    do_access("lh_signed_lo", 1'b0, 2'b01, 1'b1, 32'h10, 32'd0, 32'h7777_8001, 32'h10, 4'b0011, 32'd0, 32'hFFFF_8001);
    do_access("lb_unsigned_l1", 1'b0, 2'b00, 1'b0, 32'h5, 32'd0, 32'h0000_F100, 32'h4, 4'b0010, 32'd0, 32'h0000_00F1);
    do_access("lw", 1'b0, 2'b10, 1'b1, 32'h80, 32'd0, 32'h8123_4567, 32'h80, 4'b1111, 32'd0, 32'h8123_4567);
  endtask

  task automatic test_stores;
    do_access("sb", 1'b1, 2'b00, 1'b0, 32'h41, 32'h1234_56A5, 32'hFFFF_FFFF, 32'h40, 4'b0010, 32'hA5A5_A5A5, 32'd0);
    do_access("sh", 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_BEEF, 32'd0, 32'h20, 4'b1100, 32'hBEEF_BEEF, 32'd0);
    do_access("sw", 1'b1, 2'b11, 1'b0, 32'h34, 32'hCAFE_F00D, 32'd0, 32'h34, 4'b1111, 32'hCAFE_F00D, 32'd0);
  endtask

  task automatic test_misalign(input string nm, input logic [1:0] sz, input logic [31:0] a);
    issue(1'b0, sz, 1'b0, a, 32'd0);
    chk({nm, "_no_mem_req"}, {31'd0, mem_req}, 32'd0);
    chk({nm, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({nm, "_rsp_err"}, {30'd0, rsp_err}, 32'd1);
    chk({nm, "_rsp_rdata"}, rsp_rdata, 32'd0);
    step;
    chk({nm, "_no_mem_req2"}, {31'd0, mem_req}, 32'd0);
    chk({nm, "_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic test_timeout;
    int n = 0;
    issue(1'b0, 2'b10, 1'b0, 32'h300, 32'd0);
    while (mem_req && n < 20) begin
      n++;
      step;
    end
    chk("to_req_cycles", n, 32'd4);
    chk("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("to_rsp_err", {30'd0, rsp_err}, 32'd2);
    chk("to_rsp_rdata", rsp_rdata, 32'd0);
    step;
    issue(1'b0, 2'b10, 1'b0, 32'h300, 32'd0);
    step; step; step;
    chk("ack4_mem_req", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step;
    mem_ack = 1'b0;
    chk("ack4_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("ack4_rsp_err", {30'd0, rsp_err}, 32'd0);
    chk("ack4_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
    step;
  endtask

  task automatic test_stray_ack;
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    step;
    mem_ack = 1'b0;
    chk("stray_ack_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("stray_ack_ready", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic test_reset_mid;
    issue(1'b0, 2'b10, 1'b0, 32'h500, 32'd0);
    step;
    chk("rm_mem_req", {31'd0, mem_req}, 32'd1);
    rstn = 1'b0;
    step;
    chk("rm_req_drop", {31'd0, mem_req}, 32'd0);
    chk("rm_no_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("rm_ready_low", {31'd0, req_ready}, 32'd0);
    rstn = 1'b1;
    #1;
    chk("rm_ready", {31'd0, req_ready}, 32'd1);
    step;
    chk("rm_no_rsp2", {31'd0, rsp_valid}, 32'd0);
    chk("rm_no_req2", {31'd0, mem_req}, 32'd0);
  endtask

  task automatic test_back_to_back;
    int n = 0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_ext = 1'b0; req_addr = 32'h600;
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
    for (int i = 0; i < 6; i++) begin
      if (req_ready) n++;
      step;
    end
    req_valid = 1'b0; mem_ack = 1'b0;
    chk("b2b_accepts", n, 32'd2);
    chk("b2b_rdata", rsp_rdata, 32'h0BAD_F00D);
    step;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_loads;
    test_stores;
    test_misalign("mis_word", 2'b10, 32'h6);
    test_misalign("mis_half", 2'b01, 32'h201);
    test_misalign("mis_size3", 2'b11, 32'h2);
    test_timeout;
    test_stray_ack;
    test_reset_mid;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
